// File: rtl/light_crypto_pkg.sv
// Shared widths and the verifier state encoding for the light crypto datapath.
package light_crypto_pkg;

  localparam int LIGHT_BLOCK_W = 640;
  localparam int LIGHT_TAG_W   = 128;
  localparam int LIGHT_BEAT_W  = 64;
  localparam int LIGHT_CNT_W   = 16;
  localparam int LIGHT_BEATS   = LIGHT_BLOCK_W / LIGHT_BEAT_W;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    STREAM,
    ERR
  } verify_state_e;

  // Counter width for a given beat count; never narrower than one bit.
  function automatic int beat_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/light_block_serializer.sv
// Slices a held wide word into DATA_W beats, least-significant beat first,
// with registered val/data/last outputs.
module light_block_serializer
  import light_crypto_pkg::*;
#(
  parameter int BLOCK_W = LIGHT_BLOCK_W,
  parameter int DATA_W  = LIGHT_BEAT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] word,
  input  logic               start,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_val,
  input  logic               out_rdy,
  output logic               out_last,
  output logic               done
);

  localparam int BEATS = BLOCK_W / DATA_W;
  localparam int CW    = beat_cnt_w(BEATS);
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  logic [CW-1:0]     beat_idx;
  logic [CW-1:0]     next_idx;
  logic [DATA_W-1:0] beat_mux;
  logic              fire;

  assign fire     = out_val && out_rdy;
  assign done     = fire && out_last;
  assign next_idx = start ? '0 : beat_idx + CW'(1);

  always_comb begin
    beat_mux = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (next_idx == CW'(k)) beat_mux = word[k*DATA_W +: DATA_W];
    end
  end

  // Outputs only move on start or acceptance, so they hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_idx <= '0;
      out_val  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (start) begin
      beat_idx <= '0;
      out_val  <= 1'b1;
      out_data <= beat_mux;
      out_last <= (next_idx == LAST_IDX);
    end else if (fire) begin
      if (out_last) begin
        beat_idx <= '0;
        out_val  <= 1'b0;
        out_data <= '0;
        out_last <= 1'b0;
      end else begin
        beat_idx <= next_idx;
        out_data <= beat_mux;
        out_last <= (next_idx == LAST_IDX);
      end
    end
  end

endmodule

// File: rtl/light_decrypt_verifier.sv
// Joins a decrypted block with its expected tag, compares tags in constant time,
// then streams the plaintext on a match or emits a single error beat on a mismatch.
module light_decrypt_verifier
  import light_crypto_pkg::*;
#(
  parameter int BLOCK_W = LIGHT_BLOCK_W,
  parameter int TAG_W   = LIGHT_TAG_W,
  parameter int DATA_W  = LIGHT_BEAT_W,
  parameter int CNT_W   = LIGHT_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] in_plaintext,
  input  logic [TAG_W-1:0]   in_hmac,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [TAG_W-1:0]   tag,
  input  logic               tag_val,
  output logic               tag_rdy,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_val,
  input  logic               out_rdy,
  output logic               out_last,
  output logic               out_err,
  output logic               auth_fail,
  output logic [CNT_W-1:0]   fail_count
);

  verify_state_e state, state_n;

  logic               blk_held, tag_held;
  logic [BLOCK_W-1:0] held_pt;
  logic [TAG_W-1:0]   held_hmac, held_tag;
  logic               in_fire, tag_fire;
  logic               match;
  logic               ser_start, ser_val, ser_last, ser_done;
  logic [DATA_W-1:0]  ser_data;
  logic               err_val, err_fire;

  assign in_rdy   = !rst && (state == IDLE) && !blk_held;
  assign tag_rdy  = !rst && (state == IDLE) && !tag_held;
  assign in_fire  = in_val && in_rdy;
  assign tag_fire = tag_val && tag_rdy;
  assign err_fire = err_val && out_rdy;

  // Full-width XOR reduce: every bit participates regardless of where tags differ.
  assign match = ~|(held_hmac ^ held_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if ((blk_held || in_fire) && (tag_held || tag_fire)) state_n = CHECK;
      CHECK:   state_n = match ? STREAM : ERR;
      STREAM:  if (ser_done) state_n = IDLE;
      ERR:     if (err_fire) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_held  <= 1'b0;
      tag_held  <= 1'b0;
      held_pt   <= '0;
      held_hmac <= '0;
      held_tag  <= '0;
    end else begin
      if (in_fire) begin
        blk_held  <= 1'b1;
        held_pt   <= in_plaintext;
        held_hmac <= in_hmac;
      end else if (state == CHECK) begin
        blk_held <= 1'b0;
      end
      if (tag_fire) begin
        tag_held <= 1'b1;
        held_tag <= tag;
      end else if (state == CHECK) begin
        tag_held <= 1'b0;
      end
    end
  end

  // held_pt stays stable through STREAM because no new block is accepted outside IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_start  <= 1'b0;
      err_val    <= 1'b0;
      auth_fail  <= 1'b0;
      fail_count <= '0;
    end else begin
      ser_start <= (state == CHECK) && match;
      if ((state == CHECK) && !match) err_val <= 1'b1;
      else if (err_fire)              err_val <= 1'b0;
      if (err_fire) begin
        auth_fail <= 1'b1;
        if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
      end
    end
  end

  light_block_serializer #(
    .BLOCK_W (BLOCK_W),
    .DATA_W  (DATA_W)
  ) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .word     (held_pt),
    .start    (ser_start),
    .out_data (ser_data),
    .out_val  (ser_val),
    .out_rdy  (out_rdy),
    .out_last (ser_last),
    .done     (ser_done)
  );

  // Serializer data is zero whenever it is idle, so the error beat carries no plaintext.
  assign out_val  = ser_val | err_val;
  assign out_data = ser_data;
  assign out_last = ser_last | err_val;
  assign out_err  = err_val;

endmodule

// File: tb/tb_light_decrypt_verifier.sv
// Scoreboard bench for light_decrypt_verifier: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_light_decrypt_verifier;
  import light_crypto_pkg::*;

  localparam int BLOCK_W = 640;
  localparam int TAG_W   = 128;
  localparam int DATA_W  = 64;
  localparam int CNT_W   = 2;
  localparam int BEATS   = BLOCK_W / DATA_W;

  localparam logic [TAG_W-1:0] TAG_A = 128'hA5A5_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [TAG_W-1:0] TAG_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              err;
  } beat_t;

  logic               clk, rst;
  logic [BLOCK_W-1:0] in_plaintext;
  logic [TAG_W-1:0]   in_hmac, tag;
  logic               in_val, in_rdy, tag_val, tag_rdy;
  logic [DATA_W-1:0]  out_data;
  logic               out_val, out_rdy, out_last, out_err, auth_fail;
  logic [CNT_W-1:0]   fail_count;

  beat_t exp_q[$];
  beat_t mon_e;
  int    checks_total, checks_passed, beats_seen;
  logic  prev_stall, prev_last, prev_err;
  logic [DATA_W-1:0] prev_data;

  light_decrypt_verifier #(
    .BLOCK_W (BLOCK_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_plaintext (in_plaintext),
    .in_hmac      (in_hmac),
    .in_val       (in_val),
    .in_rdy       (in_rdy),
    .tag          (tag),
    .tag_val      (tag_val),
    .tag_rdy      (tag_rdy),
    .out_data     (out_data),
    .out_val      (out_val),
    .out_rdy      (out_rdy),
    .out_last     (out_last),
    .out_err      (out_err),
    .auth_fail    (auth_fail),
    .fail_count   (fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic failNow(input string name);
    checks_total++;
    $display("[TB] FAIL %s: bound expired or unexpected event", name);
  endtask

  // Monitor: compare each accepted beat and check stability across stalls.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_val", 64'(out_val), 64'd1);
        checkOutput("stall_data", out_data, prev_data);
        checkOutput("stall_last", 64'(out_last), 64'(prev_last));
        checkOutput("stall_err", 64'(out_err), 64'(prev_err));
      end
      if (out_val && out_rdy) begin
        if (exp_q.size() == 0) begin
          failNow("unexpected_beat");
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("beat_data", out_data, mon_e.data);
          checkOutput("beat_last", 64'(out_last), 64'(mon_e.last));
          checkOutput("beat_err", 64'(out_err), 64'(mon_e.err));
        end
        beats_seen++;
      end
      prev_stall = out_val && !out_rdy;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_err   = out_err;
    end
  end

  // Pushes expected beats, then presents block and tag after the given cycle delays.
  task automatic applyStimulus(input logic [BLOCK_W-1:0] pt, input logic [TAG_W-1:0] hm,
                               input logic [TAG_W-1:0] tg, input int blk_delay,
                               input int tag_delay, input bit exp_match, input bit chk_lat);
    beat_t b;
    bit    b_done, t_done, b_fire, t_fire;
    int    cyc, lat;
    if (exp_match) begin
      for (int k = 0; k < BEATS; k++) begin
        b.data = pt[k*DATA_W +: DATA_W];
        b.last = (k == BEATS - 1);
        b.err  = 1'b0;
        exp_q.push_back(b);
      end
    end else begin
      b.data = '0;
      b.last = 1'b1;
      b.err  = 1'b1;
      exp_q.push_back(b);
    end
    in_plaintext = pt;
    in_hmac      = hm;
    tag          = tg;
    b_done = 0; t_done = 0; cyc = 0;
    while (!(b_done && t_done) && cyc < 50) begin
      in_val  = !b_done && (cyc >= blk_delay);
      tag_val = !t_done && (cyc >= tag_delay);
      @(negedge clk);
      b_fire = in_val && in_rdy;
      t_fire = tag_val && tag_rdy;
      @(posedge clk); #1;
      if (b_fire) b_done = 1;
      if (t_fire) t_done = 1;
      cyc++;
    end
    in_val  = 1'b0;
    tag_val = 1'b0;
    if (!(b_done && t_done)) begin
      failNow("input_accept");
      return;
    end
    checkOutput("in_rdy_after_join", 64'(in_rdy), 64'd0);
    checkOutput("tag_rdy_after_join", 64'(tag_rdy), 64'd0);
    if (chk_lat) begin
      lat = 0;
      while (!out_val && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      checkOutput("first_beat_latency", 64'(lat), 64'd2);
    end
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(exp_q.size() == 0 && !out_val) && n < 200);
    if (n >= 200) failNow(name);
  endtask

  logic [BLOCK_W-1:0] pt_b, pt_c;
  logic [CNT_W-1:0]   sat_exp [5];
  int base, n;

  initial begin
    checks_total = 0; checks_passed = 0; beats_seen = 0;
    prev_stall = 0; prev_data = '0; prev_last = 0; prev_err = 0;
    rst = 1'b1; in_val = 0; tag_val = 0; out_rdy = 1'b1;
    in_plaintext = '0; in_hmac = '0; tag = '0;
    pt_b = {64'h1111, 64'h2222, 64'h3333, 64'h4444, 64'h5555,
            64'h6666, 64'h7777, 64'h8888, 64'h9999, 64'hDEAD_BEEF_0000_0001};
    for (int k = 0; k < BEATS; k++) pt_c[k*DATA_W +: DATA_W] = 64'h1000 + 64'(k);
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    repeat (2) @(posedge clk); #1;
    checkOutput("rst_out_val", 64'(out_val), 64'd0);
    checkOutput("rst_out_data", out_data, 64'd0);
    checkOutput("rst_out_last", 64'(out_last), 64'd0);
    checkOutput("rst_out_err", 64'(out_err), 64'd0);
    checkOutput("rst_auth_fail", 64'(auth_fail), 64'd0);
    checkOutput("rst_fail_count", 64'(fail_count), 64'd0);
    checkOutput("rst_in_rdy", 64'(in_rdy), 64'd0);
    checkOutput("rst_tag_rdy", 64'(tag_rdy), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_in_rdy", 64'(in_rdy), 64'd1);
    checkOutput("idle_tag_rdy", 64'(tag_rdy), 64'd1);

    $display("[TB] match, same-edge join");
    applyStimulus(640'd5, TAG_A, TAG_A, 0, 0, 1, 1);
    waitDone("match_done");
    checkOutput("match_auth_fail", 64'(auth_fail), 64'd0);
    checkOutput("match_fail_count", 64'(fail_count), 64'd0);

    $display("[TB] mismatch");
    applyStimulus(640'd5, TAG_A, 128'h0, 0, 0, 0, 0);
    waitDone("mismatch_done");
    checkOutput("mismatch_auth_fail", 64'(auth_fail), 64'd1);
    checkOutput("mismatch_fail_count", 64'(fail_count), 64'd1);

    $display("[TB] ordering: tag first, then block first");
    applyStimulus(pt_b, TAG_B, TAG_B, 3, 0, 1, 1);
    waitDone("tag_first_done");
    applyStimulus(pt_b, TAG_B, TAG_B, 0, 3, 1, 1);
    waitDone("blk_first_done");
    checkOutput("order_fail_count", 64'(fail_count), 64'd1);

    $display("[TB] backpressure on beat 3");
    base = beats_seen;
    applyStimulus(640'd5, TAG_A, TAG_A, 0, 0, 1, 1);
    n = 0;
    while (beats_seen - base < 3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) failNow("bp_reach_beat3");
    out_rdy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("bp_held_val", 64'(out_val), 64'd1);
    checkOutput("bp_held_data", out_data, 64'd0);
    out_rdy = 1'b1;
    waitDone("bp_done");
    checkOutput("bp_beat_total", 64'(beats_seen - base), 64'd10);

    $display("[TB] reset mid-stream at beat 5");
    base = beats_seen;
    applyStimulus(pt_c, TAG_B, TAG_B, 0, 0, 1, 1);
    n = 0;
    while (beats_seen - base < 5 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) failNow("rst_reach_beat5");
    checkOutput("pre_rst_beat5", out_data, 64'h1005);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    checkOutput("mid_rst_out_val", 64'(out_val), 64'd0);
    checkOutput("mid_rst_out_data", out_data, 64'd0);
    checkOutput("mid_rst_out_last", 64'(out_last), 64'd0);
    checkOutput("mid_rst_fail_count", 64'(fail_count), 64'd0);
    checkOutput("mid_rst_auth_fail", 64'(auth_fail), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(640'd10, TAG_A, TAG_A, 0, 0, 1, 1);
    checkOutput("post_rst_beat0", out_data, 64'd10);
    waitDone("post_rst_done");

    $display("[TB] fail counter saturation");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(640'd7 + BLOCK_W'(i), TAG_A, ~TAG_A, 0, 0, 0, 0);
      waitDone("sat_done");
      checkOutput("sat_fail_count", 64'(fail_count), 64'(sat_exp[i]));
      checkOutput("sat_auth_fail", 64'(auth_fail), 64'd1);
    end

    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
